// File: rtl/wb_master_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Timeout feature is enabled with the WB_ARB_TIMEOUT_EN macro.
package wb_master_arbiter_pkg;

   localparam int WB_ADR_W = 8;
   localparam int WB_DAT_W = 8;

   localparam logic [WB_DAT_W-1:0] WB_TO_DATA = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

endpackage

// File: rtl/wb_master_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the decoder.
// The master modport is the arbiter's view; slave is the environment's.
interface wb_master_arbiter_if;
   import wb_master_arbiter_pkg::*;

   logic [WB_ADR_W-1:0] m0_adr_i;
   logic [WB_ADR_W-1:0] m1_adr_i;
   logic [WB_DAT_W-1:0] m0_dat_i;
   logic [WB_DAT_W-1:0] m1_dat_i;
   logic [WB_DAT_W-1:0] m0_dat_o;
   logic [WB_DAT_W-1:0] m1_dat_o;
   logic                m0_cyc_i;
   logic                m0_stb_i;
   logic                m0_we_i;
   logic                m1_cyc_i;
   logic                m1_stb_i;
   logic                m1_we_i;
   logic                m0_ack_o;
   logic                m1_ack_o;
   logic [WB_ADR_W-1:0] s_adr_o;
   logic [WB_DAT_W-1:0] s_dat_o;
   logic                s_cyc_o;
   logic                s_stb_o;
   logic                s_we_o;
   logic [WB_DAT_W-1:0] s_dat_i;
   logic                s_ack_i;
   logic [1:0]          gnt_o;
   logic                timeout_o;

   modport master (
      input  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i,
      input  m0_cyc_i, m0_stb_i, m0_we_i,
      input  m1_cyc_i, m1_stb_i, m1_we_i,
      input  s_dat_i, s_ack_i,
      output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o,
      output s_adr_o, s_dat_o, s_cyc_o, s_stb_o, s_we_o,
      output gnt_o, timeout_o
   );

   modport slave (
      output m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i,
      output m0_cyc_i, m0_stb_i, m0_we_i,
      output m1_cyc_i, m1_stb_i, m1_we_i,
      output s_dat_i, s_ack_i,
      input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o,
      input  s_adr_o, s_dat_o, s_cyc_o, s_stb_o, s_we_o,
      input  gnt_o, timeout_o
   );

endinterface

// File: rtl/wb_arb_timeout.sv
// Stall counter for the arbiter: flags a forced termination after
// TIMEOUT_CYCLES consecutive unacknowledged strobe cycles.
module wb_arb_timeout #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic stall_i,
   output logic hit_o
);

   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            hit_q, hit_d;

   // hit is registered so the forced ack lands the cycle after the limit
   always_comb begin
      hit_d = stall_i && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
      cnt_d = (stall_i && !hit_d) ? cnt_q + 1'b1 : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         hit_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         hit_q <= hit_d;
      end
   end

   assign hit_o = hit_q;

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter, grant held for a whole cyc.
// Define WB_ARB_TIMEOUT_EN to terminate stalled strobes after a timeout.
module wb_master_arbiter
   import wb_master_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   wb_master_arbiter_if.master bus
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES >= (1 << TO_W))
   begin : g_cfg_err
      $error("wb_master_arbiter: bad TIMEOUT_CYCLES/TO_W");
   end

   arb_state_e state_q, state_d;
   logic       last_q, last_d;
   logic [1:0] gnt_q, gnt_d;
   logic       to_hit;

   // last_q = 1 means master 1 was served last, so master 0 wins a tie
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (bus.m0_cyc_i && (!bus.m1_cyc_i || last_q)) begin
               state_d = GNT0;
               last_d  = 1'b0;
            end else if (bus.m1_cyc_i) begin
               state_d = GNT1;
               last_d  = 1'b1;
            end
         end
         GNT0:    if (!bus.m0_cyc_i) state_d = IDLE;
         GNT1:    if (!bus.m1_cyc_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      gnt_d = {state_d == GNT1, state_d == GNT0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         gnt_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
      end
   end

   always_comb begin
      bus.s_adr_o  = '0;
      bus.s_dat_o  = '0;
      bus.s_cyc_o  = 1'b0;
      bus.s_stb_o  = 1'b0;
      bus.s_we_o   = 1'b0;
      bus.m0_ack_o = 1'b0;
      bus.m0_dat_o = '0;
      bus.m1_ack_o = 1'b0;
      bus.m1_dat_o = '0;
      case (state_q)
         GNT0: begin
            bus.s_adr_o  = bus.m0_adr_i;
            bus.s_dat_o  = bus.m0_dat_i;
            bus.s_cyc_o  = bus.m0_cyc_i;
            bus.s_stb_o  = bus.m0_stb_i & ~to_hit;
            bus.s_we_o   = bus.m0_we_i;
            bus.m0_ack_o = bus.s_ack_i | to_hit;
            bus.m0_dat_o = to_hit ? WB_TO_DATA : bus.s_dat_i;
         end
         GNT1: begin
            bus.s_adr_o  = bus.m1_adr_i;
            bus.s_dat_o  = bus.m1_dat_i;
            bus.s_cyc_o  = bus.m1_cyc_i;
            bus.s_stb_o  = bus.m1_stb_i & ~to_hit;
            bus.s_we_o   = bus.m1_we_i;
            bus.m1_ack_o = bus.s_ack_i | to_hit;
            bus.m1_dat_o = to_hit ? WB_TO_DATA : bus.s_dat_i;
         end
         default: ;
      endcase
   end

`ifdef WB_ARB_TIMEOUT_EN
   logic stall;

   assign stall = bus.s_cyc_o & bus.s_stb_o & ~bus.s_ack_i;

   wb_arb_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_W           (TO_W)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .stall_i (stall),
      .hit_o   (to_hit)
   );
`else
   assign to_hit = 1'b0;
`endif

   assign bus.gnt_o     = gnt_q;
   assign bus.timeout_o = to_hit;

endmodule
